// File: rtl/hyper_pkg.sv
// HyperBus RX capture: shared types and constants.
// Imported by the capture controller and its RX word FIFO.
package hyper_pkg;

  localparam int unsigned HYPER_WORD_W = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_LATENCY,
    RX_CAPTURE,
    RX_FLUSH
  } rx_state_e;

endpackage

// File: rtl/ddr_in.sv
// Single-bit DDR input lane: rising byte bit, then falling byte bit.
// The falling capture follows the rising one by half a cycle.
module ddr_in (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic q_pos_o,
  output logic q_neg_o
);

  logic pos_q, pos_d;
  logic neg_q, neg_d;
  logic en_dly_q, en_dly_d;

  // next-state: hold unless this half-cycle belongs to an enabled beat
  always_comb begin
    en_dly_d = en_i;
    pos_d    = en_i ? d_i : pos_q;
    neg_d    = en_dly_q ? d_i : neg_q;
  end

  // rising-edge sample and enable delay for the falling half
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q    <= 1'b0;
      en_dly_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      en_dly_q <= en_dly_d;
    end
  end

  // falling-edge sample of the same beat
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) neg_q <= 1'b0;
    else         neg_q <= neg_d;
  end

  assign q_pos_o = pos_q;
  assign q_neg_o = neg_q;

endmodule

// File: rtl/hyper_rx_fifo.sv
// Synchronous RX word FIFO with flush.
// A pop frees a slot for a push in the same cycle even when full.
module hyper_rx_fifo
  import hyper_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [HYPER_WORD_W-1:0] data_i,
  input  logic                    pop_i,
  output logic [HYPER_WORD_W-1:0] data_o,
  output logic                    empty_o,
  output logic                    full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [HYPER_WORD_W-1:0] mem_q [DEPTH];
  logic do_pop, do_push;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  // pointer update, flush wins
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + ONE;
      if (do_pop)  rptr_d = rptr_q + ONE;
    end
  end

  // pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // storage; contents are masked while empty so no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/hyper_rx_capture_ctrl.sv
// HyperBus read capture: latency wait, gated DDR lanes, word packing.
// Packed words go through a small FIFO toward the RX channel.
module hyper_rx_capture_ctrl
  import hyper_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned LAT_W      = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        burst_len_i,
  input  logic [LAT_W-1:0]        latency_i,
  input  logic                    abort_i,
  input  logic [7:0]              dq_i,
  output logic [HYPER_WORD_W-1:0] rx_data_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o
);

  rx_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             en_q, en_d;
  logic             push_q, push_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [7:0] pos_byte, neg_byte;
  logic       fifo_empty, fifo_full;
  logic       drop;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    ddr_in u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (en_q),
      .d_i     (dq_i[g]),
      .q_pos_o (pos_byte[g]),
      .q_neg_o (neg_byte[g])
    );
  end

  hyper_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (abort_i),
    .push_i  (push_q),
    .data_i  ({pos_byte, neg_byte}),
    .pop_i   (rx_ready_i),
    .data_o  (rx_data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rx_valid_o = !fifo_empty;
  assign drop = push_q && fifo_full && !rx_ready_i && !abort_i;

  // sequencing: latency count, word count, push strobe, status
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lat_d   = lat_q;
    push_d  = en_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      RX_IDLE: begin
        if (start_i) begin
          ovf_d = 1'b0;
          len_d = burst_len_i;
          lat_d = latency_i;
          if (burst_len_i == '0)    done_d  = 1'b1;
          else if (latency_i != '0) state_d = RX_LATENCY;
          else                      state_d = RX_CAPTURE;
        end
      end
      RX_LATENCY: begin
        if (lat_q == LAT_W'(1)) state_d = RX_CAPTURE;
        else                    lat_d   = lat_q - LAT_W'(1);
      end
      RX_CAPTURE: begin
        len_d = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1)) state_d = RX_FLUSH;
      end
      RX_FLUSH: begin
        state_d = RX_IDLE;
        done_d  = 1'b1;
      end
    endcase
    if (drop) ovf_d = 1'b1;
    if (abort_i) begin
      state_d = RX_IDLE;
      push_d  = 1'b0;
      done_d  = 1'b0;
    end
    en_d = (state_d == RX_CAPTURE);
  end

  // FSM and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
      len_q   <= '0;
      lat_q   <= '0;
      en_q    <= 1'b0;
      push_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lat_q   <= lat_d;
      en_q    <= en_d;
      push_q  <= push_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q != RX_IDLE);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_hyper_rx_capture_ctrl.sv
// Bench for hyper_rx_capture_ctrl: directed bursts plus random traffic
// against a queue-based burst/FIFO reference.
module tb_hyper_rx_capture_ctrl;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;
  localparam int LAT_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             rx_ready_i = 1'b0;
  logic [LEN_W-1:0] burst_len_i = '0;
  logic [LAT_W-1:0] latency_i = '0;
  logic [7:0]       dq_i = '0;
  logic [15:0]      rx_data_o;
  logic             rx_valid_o, busy_o, done_o, overflow_o;

  int n_cmp = 0;
  int n_bad = 0;
  int pc = 0;

  logic [7:0] rb [8192];
  logic [7:0] fb [8192];

  logic [15:0] q[$];
  bit act, m_done, m_ovf;
  int s, m_lat, m_len;

  hyper_rx_capture_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LEN_W),
    .LAT_W      (LAT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .latency_i   (latency_i),
    .abort_i     (abort_i),
    .dq_i        (dq_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // pads: rb[k] is on DQ at posedge k, fb[k] at the negedge after it
  initial begin
    forever begin
      @(posedge clk_i);
      pc++;
      #1 dq_i = fb[pc];
      @(negedge clk_i);
      #1 dq_i = rb[pc+1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h at cycle %0d", tag, got, exp, pc);
    end
  endtask

  // one clock: reference update from the inputs seen at the edge, then compare
  task automatic cyc();
    bit r_rst = rst_ni;
    bit r_st  = start_i;
    bit r_ab  = abort_i;
    bit r_rdy = rx_ready_i;
    int r_len = int'(burst_len_i);
    int r_lat = int'(latency_i);
    bit was;
    bit m_en;
    @(posedge clk_i);
    #2;
    if (!r_rst) begin
      q.delete(); act = 0; m_ovf = 0; m_done = 0;
    end else if (r_ab) begin
      q.delete(); act = 0; m_done = 0;
    end else begin
      was = act;
      m_done = 0;
      if (r_rdy && q.size() > 0) void'(q.pop_front());
      if (act && pc >= s + m_lat + 2 && pc <= s + m_lat + m_len + 1) begin
        if (q.size() < DEPTH) q.push_back({rb[pc-1], fb[pc-1]});
        else m_ovf = 1;
      end
      if (act && pc == s + m_lat + m_len + 1) begin
        act = 0; m_done = 1;
      end
      if (r_st && !was) begin
        m_ovf = 0;
        if (r_len == 0) m_done = 1;
        else begin
          act = 1; s = pc; m_lat = r_lat; m_len = r_len;
        end
      end
    end
    m_en = act && pc >= s + m_lat && pc <= s + m_lat + m_len - 1;
    chk("valid", 32'(rx_valid_o), 32'(q.size() > 0));
    chk("data", 32'(rx_data_o), q.size() > 0 ? 32'(q[0]) : 32'd0);
    chk("busy", 32'(busy_o), 32'(act));
    chk("done", 32'(done_o), 32'(m_done));
    chk("ovf", 32'(overflow_o), 32'(m_ovf));
    chk("lane_en", 32'(dut.en_q), 32'(m_en));
  endtask

  task automatic go(input int len, input int lat);
    start_i = 1;
    burst_len_i = LEN_W'(len);
    latency_i = LAT_W'(lat);
    cyc();
    start_i = 0;
  endtask

  initial begin
    int s0, first, nd, nv, ne;
    logic [15:0] got[$];
    logic [15:0] exp_w;

    for (int i = 0; i < 8192; i++) begin
      rb[i] = 8'($urandom);
      fb[i] = 8'($urandom);
    end

    cyc();
    cyc();
    rst_ni = 1;
    cyc();
    cyc();

    // len=4 lat=3 with known byte pattern
    rx_ready_i = 1;
    s0 = pc + 1;
    for (int i = 0; i < 4; i++) begin
      rb[s0+4+i] = 8'(8'h11 + 8'h22 * i);
      fb[s0+4+i] = 8'(8'h22 + 8'h22 * i);
    end
    first = -1; nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) go(4, 3); else cyc();
      if (rx_valid_o && first < 0) first = pc - s0;
      if (rx_valid_o) got.push_back(rx_data_o);
      if (done_o) nd++;
    end
    chk("first_valid_lat", 32'(first), 32'd5);
    chk("n_words", 32'(got.size()), 32'd4);
    chk("n_done", 32'(nd), 32'd1);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      exp_w = 16'(16'h1122 + 16'h2222 * i);
      chk("word", 32'(got[i]), 32'(exp_w));
    end

    // zero-length burst
    go(0, 7);
    chk("len0_done", 32'(done_o), 32'd1);
    nv = 0; ne = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rx_valid_o) nv++;
      if (dut.en_q) ne++;
    end
    chk("len0_no_valid", 32'(nv), 32'd0);
    chk("len0_no_en", 32'(ne), 32'd0);

    // overflow with consumer stalled
    rx_ready_i = 0;
    nd = 0;
    go(8, 1);
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (done_o) nd++;
    end
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_done", 32'(nd), 32'd1);
    rx_ready_i = 1;
    for (int i = 0; i < 6; i++) cyc();
    go(1, 0);
    chk("ovf_cleared", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 5; i++) cyc();

    // full FIFO popped on the same edge as a push
    rx_ready_i = 0;
    go(6, 0);
    for (int i = 0; i < 5; i++) cyc();
    chk("full_before_pop", 32'(dut.fifo_full), 32'd1);
    rx_ready_i = 1;
    for (int i = 0; i < 10; i++) cyc();
    chk("full_pop_no_ovf", 32'(overflow_o), 32'd0);

    // abort on 2nd capture cycle, with a start in the same cycle
    go(16, 0);
    cyc();
    abort_i = 1;
    go(5, 2);
    abort_i = 0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_valid", 32'(rx_valid_o), 32'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done_o) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);

    // asynchronous reset mid-capture
    go(10, 1);
    for (int i = 0; i < 4; i++) cyc();
    #1 rst_ni = 0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_data", 32'(rx_data_o), 32'd0);
    cyc();
    rst_ni = 1;
    cyc();
    go(3, 2);
    for (int i = 0; i < 10; i++) cyc();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rx_ready_i = ($urandom_range(9) < 7);
      abort_i = ($urandom_range(59) == 0);
      start_i = 0;
      if ($urandom_range(3) == 0) begin
        start_i = 1;
        burst_len_i = LEN_W'($urandom_range(12));
        latency_i = LAT_W'($urandom_range(6));
      end
      cyc();
    end
    start_i = 0;
    abort_i = 0;
    rx_ready_i = 1;
    for (int i = 0; i < 30; i++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
